// File: rtl/uart_tx_port.sv
// uart_tx_port: memory-mapped 8N1 UART transmitter for one bus-hub device slot.
//
// Register window (16 bytes at BASE_ADDR, select = addr[3:2]):
//   0 DATA   : write pushes wdata[7:0] into the TX FIFO (lane 0); reads 0
//   1 STATUS : {count[8:4], overflow[3], busy[2], empty[1], full[0]}; write 1 to bit 3 clears overflow
//   2 DIV    : baud divisor (clocks per bit), byte-lane writable; reads {16'b0, div}
//   3        : reads 0, writes ignored
//
// Ports:
//   clk, rst         : core clock, synchronous active-high reset
//   addr/wdata/wmask : hub request address, write data, byte-lane enables
//   ren/wen          : read/write requests, held by the host until ready
//   rdata/ready      : registered read data, one-cycle completion pulse
//   active           : combinational address-decode hit
//   tx               : serial output, idle high
module uart_tx_port #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter logic [15:0] DEFAULT_DIV = 16'd104,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  input  logic        ren,
  input  logic        wen,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        active,
  output logic        tx
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t         r_state, w_state_next;
  logic [7:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           r_overflow, r_ready, r_held;
  logic [31:0]    r_rdata;
  logic [15:0]    r_div, r_period, r_baud;
  logic [7:0]     r_shift;
  logic [2:0]     r_bitcnt;

  logic           w_full, w_empty, w_busy, w_accept, w_wr, w_rd;
  logic           w_data_wr, w_push, w_drop, w_pop, w_tick, w_tx, w_ovf_clr;
  logic [1:0]     w_sel;
  logic [15:0]    w_div_eff;
  logic [31:0]    w_status, w_rdval;
  logic           w_unused;

  assign active    = (addr[31:4] == BASE_ADDR[31:4]);
  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_busy    = (r_state != S_IDLE);
  assign w_sel     = addr[3:2];

  // r_held keeps a request that is still asserted after its ready pulse from
  // being executed a second time; it clears once the host drops ren/wen.
  assign w_accept  = active & (ren | wen) & ~r_ready & ~r_held;
  assign w_wr      = w_accept & wen;
  assign w_rd      = w_accept & ren & ~wen;
  assign w_data_wr = w_wr & (w_sel == 2'd0) & wmask[0];
  // A same-cycle pop frees a slot, so a push into a full FIFO still lands.
  assign w_push    = w_data_wr & (~w_full | w_pop);
  assign w_drop    = w_data_wr & w_full & ~w_pop;
  assign w_ovf_clr = w_wr & (w_sel == 2'd1) & wmask[0] & wdata[3];

  assign w_div_eff = (r_div == '0) ? 16'd1 : r_div;
  assign w_tick    = (r_baud == r_period - 16'd1);

  assign w_status  = {23'b0, 5'(r_count), r_overflow, w_busy, w_empty, w_full};

  always_comb begin
    w_rdval = '0;
    case (w_sel)
      2'd1:    w_rdval = w_status;
      2'd2:    w_rdval = {16'b0, r_div};
      default: w_rdval = '0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_tx         = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = S_START;
        end
      end
      S_START: begin
        w_tx = 1'b0;
        if (w_tick) w_state_next = S_DATA;
      end
      S_DATA: begin
        w_tx = r_shift[0];
        if (w_tick && (r_bitcnt == 3'd7)) w_state_next = S_STOP;
      end
      S_STOP: begin
        if (w_tick) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign tx    = w_tx;
  assign ready = r_ready;
  assign rdata = r_rdata;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_ready    <= 1'b0;
      r_held     <= 1'b0;
      r_rdata    <= '0;
      r_div      <= DEFAULT_DIV;
      r_period   <= 16'd1;
      r_baud     <= '0;
      r_shift    <= '1;
      r_bitcnt   <= '0;
    end else begin
      r_ready <= w_accept;
      r_held  <= (ren | wen) ? (r_held | w_accept) : 1'b0;
      // Cleared on every non-accept cycle, so rdata is 0 whenever ready is 0.
      r_rdata <= w_rd ? w_rdval : '0;

      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      if (w_drop)         r_overflow <= 1'b1;
      else if (w_ovf_clr) r_overflow <= 1'b0;

      if (w_wr && (w_sel == 2'd2)) begin
        if (wmask[0]) r_div[7:0]  <= wdata[7:0];
        if (wmask[1]) r_div[15:8] <= wdata[15:8];
      end

      // The bit period is latched at each bit boundary, so a DIV write never
      // stretches or shortens the bit currently on the line.
      if (w_pop) begin
        r_shift  <= r_mem[r_rd_ptr];
        r_bitcnt <= '0;
        r_baud   <= '0;
        r_period <= w_div_eff;
      end else if (w_busy) begin
        if (w_tick) begin
          r_baud   <= '0;
          r_period <= w_div_eff;
          if (r_state == S_DATA) begin
            r_shift  <= r_shift >> 1;
            r_bitcnt <= r_bitcnt + 3'd1;
          end
        end else begin
          r_baud <= r_baud + 16'd1;
        end
      end
    end
  end

  assign w_unused = &{1'b0, addr[1:0], wdata[31:16], wmask[3:2]};

endmodule

// File: tb/tb_uart_tx_port.sv
module tb_uart_tx_port;

  localparam logic [31:0] BASE   = 32'h0000_1000;
  localparam logic [31:0] A_DATA = BASE + 32'h0;
  localparam logic [31:0] A_STAT = BASE + 32'h4;
  localparam logic [31:0] A_DIV  = BASE + 32'h8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wmask = '0;
  logic        ren = 1'b0;
  logic        wen = 1'b0;
  logic [31:0] rdata;
  logic        ready, active, tx;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  uart_tx_port #(
    .BASE_ADDR  (BASE),
    .DEFAULT_DIV(16'd104),
    .FIFO_DEPTH (8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .wdata (wdata),
    .wmask (wmask),
    .ren   (ren),
    .wen   (wen),
    .rdata (rdata),
    .ready (ready),
    .active(active),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge one idle cycle after ready.
  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                     input logic r, input logic w, output logic [31:0] rd);
    int lat;
    addr = a; wdata = d; wmask = m; ren = r; wen = w;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ready && lat < 4);
    check("latency", 32'(lat), 32'd1);
    rd  = rdata;
    ren = 1'b0;
    wen = 1'b0;
    @(negedge clk);
    check("ready_pulse", {31'b0, ready}, 32'd0);
    check("rdata_idle", rdata, 32'd0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] x;
    bus(a, d, m, 1'b0, 1'b1, x);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] x;
    bus(a, 32'd0, 4'd0, 1'b1, 1'b0, x);
    check(tag, x, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0]  frame;
    logic [31:0] x;
    int          cnt, consec;
    logic        prev;

    repeat (3) @(negedge clk);
    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_ready", {31'b0, ready}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    rd_chk("rst_status", A_STAT, 32'h0000_0002);
    rd_chk("rst_div", A_DIV, 32'h0000_0068);

    // 0xA5 at 4 clocks per bit, sampled every clock from the first start-bit cycle.
    wr(A_DIV, 32'd4, 4'b0011);
    wr(A_DATA, 32'h0000_00A5, 4'b0001);
    frame = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 40; i++) begin
      check("frame_a5", {31'b0, tx}, {31'b0, frame[i/4]});
      @(negedge clk);
    end
    check("after_a5_tx", {31'b0, tx}, 32'd1);
    rd_chk("after_a5_status", A_STAT, 32'h0000_0002);

    // DIV=0 behaves as one clock per bit.
    wr(A_DIV, 32'd0, 4'b0011);
    wr(A_DATA, 32'h0000_005A, 4'b0001);
    frame = {1'b1, 8'h5A, 1'b0};
    for (int i = 0; i < 10; i++) begin
      check("frame_5a_div0", {31'b0, tx}, {31'b0, frame[i]});
      @(negedge clk);
    end
    rd_chk("after_5a_status", A_STAT, 32'h0000_0002);

    // Fill: first byte pops straight into the shifter, next 8 fill the FIFO.
    wr(A_DIV, 32'd1000, 4'b0011);
    for (int b = 0; b < 9; b++) wr(A_DATA, 32'(b), 4'b0001);
    rd_chk("full_status", A_STAT, 32'h0000_0085);
    wr(A_DATA, 32'h0000_0009, 4'b0001);
    rd_chk("ovf_status", A_STAT, 32'h0000_008D);
    wr(A_STAT, 32'h0000_0007, 4'b0001);
    rd_chk("w1c_nobit3", A_STAT, 32'h0000_008D);
    wr(A_STAT, 32'h0000_0008, 4'b0001);
    rd_chk("w1c_clear", A_STAT, 32'h0000_0085);

    // Reset while bit 0 of byte 0x00 is on the line.
    repeat (1100) @(negedge clk);
    check("pre_rst_tx", {31'b0, tx}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_tx", {31'b0, tx}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    rd_chk("post_rst_status", A_STAT, 32'h0000_0002);
    rd_chk("post_rst_div", A_DIV, 32'h0000_0068);
    cnt = 0;
    repeat (2000) begin
      if (!tx) cnt++;
      @(negedge clk);
    end
    check("post_rst_quiet", 32'(cnt), 32'd0);

    // ren and wen together: write wins, rdata is 0.
    bus(A_DIV, 32'h0000_0020, 4'b0011, 1'b1, 1'b1, x);
    check("rw_rdata", x, 32'd0);
    rd_chk("rw_div", A_DIV, 32'h0000_0020);
    wr(A_DIV, 32'h0000_0300, 4'b0010);
    rd_chk("div_hi_lane", A_DIV, 32'h0000_0320);

    // Held write executes once while a frame keeps the FIFO from draining.
    wr(A_DIV, 32'd1000, 4'b0011);
    wr(A_DATA, 32'h0000_0011, 4'b0001);
    addr = A_DATA; wdata = 32'h0000_0022; wmask = 4'b0001; wen = 1'b1;
    cnt = 0; consec = 0; prev = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (ready) cnt++;
      if (ready && prev) consec++;
      prev = ready;
    end
    wen = 1'b0;
    @(negedge clk);
    check("held_pulses", 32'(cnt), 32'd1);
    check("held_consec", 32'(consec), 32'd0);
    rd_chk("held_status", A_STAT, 32'h0000_0014);
    wr(A_DATA, 32'h0000_0033, 4'b1110);
    rd_chk("nolane0_status", A_STAT, 32'h0000_0014);

    // Out-of-window addresses never decode or complete.
    addr = BASE + 32'h10; ren = 1'b1; cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (ready) cnt++;
    end
    check("above_active", {31'b0, active}, 32'd0);
    check("above_ready", 32'(cnt), 32'd0);
    addr = BASE - 32'h4; cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (ready) cnt++;
    end
    check("below_active", {31'b0, active}, 32'd0);
    check("below_ready", 32'(cnt), 32'd0);
    ren = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
